// File: rtl/vga_map_pkg.sv
// Shared constants and enums for the VGA map write path.
package vga_map_pkg;

  localparam int MAP_W     = 640;
  localparam int MAP_H     = 480;
  localparam int MAP_WORDS = MAP_W * MAP_H;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} map_state_e;
  typedef enum logic [0:0] {SRC_RF = 1'b0, SRC_DP = 1'b1} map_src_e;

  // Plain-vector state encodings for the arbiter state register.
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_CLEAR = CLEAR;

endpackage

// File: rtl/vga_map_wr_arbiter_fifo.sv
// Synchronous FIFO of {addr,data} write entries.
// Handshake: push is only legal when !full or when pop is asserted in the
// same cycle; pop is only legal when !empty. The caller enforces both, so
// the FIFO itself never drops or underflows. rdata shows the head entry.
module map_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage write; a push on full lands in the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_map_wr_arbiter.sv
// Merges the rangefinder and disparity write streams into BRAM port A, one
// write per cycle, with per-source buffering and a full-map clear sweep.
// A strobe arriving while its FIFO is empty and it wins arbitration bypasses
// the FIFO so it reaches the port in the next cycle.
module vga_map_wr_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = vga_map_pkg::ADDR_W,
  parameter int DATA_W     = vga_map_pkg::DATA_W,
  parameter int MAP_WORDS  = vga_map_pkg::MAP_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_wen,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_data,
  input  logic              dp_wen,
  input  logic              mode,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_val,
  output logic [ADDR_W-1:0] vga_waddr,
  output logic [DATA_W-1:0] dina,
  output logic              ena,
  output logic              wea,
  output logic              busy,
  output logic              rf_ovf,
  output logic              dp_ovf
);

  import vga_map_pkg::*;

  localparam int                ENTRY_W    = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MAP_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAP_WORDS - 1);

  logic [0:0]        state;
  map_src_e          last_src;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val_q;

  logic               rf_full, rf_empty, dp_full, dp_empty;
  logic [ENTRY_W-1:0] rf_rdata, dp_rdata, rf_head, dp_head;
  logic rf_sel, dp_sel, rf_req, dp_req, rf_avail, dp_avail, pop_en;
  logic rf_grant, dp_grant, rf_fifo_pop, dp_fifo_pop, rf_fifo_push, dp_fifo_push;
  logic rf_drop, dp_drop;

  // Acceptance, round-robin grant, FIFO push/pop and drop detection.
  always_comb begin
    rf_sel   = rf_wen && !mode;
    dp_sel   = dp_wen && mode;
    rf_req   = rf_sel && (rf_addr < ADDR_LIMIT);
    dp_req   = dp_sel && (dp_addr < ADDR_LIMIT);
    pop_en   = (state == ST_IDLE) && !clear_req;
    rf_avail = !rf_empty || rf_req;
    dp_avail = !dp_empty || dp_req;
    rf_grant = pop_en && rf_avail && (!dp_avail || last_src == SRC_DP);
    dp_grant = pop_en && dp_avail && (!rf_avail || last_src == SRC_RF);
    rf_fifo_pop  = rf_grant && !rf_empty;
    dp_fifo_pop  = dp_grant && !dp_empty;
    rf_fifo_push = rf_req && !(rf_grant && rf_empty) && (!rf_full || rf_fifo_pop);
    dp_fifo_push = dp_req && !(dp_grant && dp_empty) && (!dp_full || dp_fifo_pop);
    rf_drop  = (rf_sel && !rf_req) || (rf_req && rf_full && !rf_fifo_pop);
    dp_drop  = (dp_sel && !dp_req) || (dp_req && dp_full && !dp_fifo_pop);
    rf_head  = rf_empty ? {rf_addr, rf_data} : rf_rdata;
    dp_head  = dp_empty ? {dp_addr, dp_data} : dp_rdata;
  end

  map_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_rf_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rf_fifo_push),
    .pop   (rf_fifo_pop),
    .wdata ({rf_addr, rf_data}),
    .rdata (rf_rdata),
    .full  (rf_full),
    .empty (rf_empty)
  );

  map_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_dp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dp_fifo_push),
    .pop   (dp_fifo_pop),
    .wdata ({dp_addr, dp_data}),
    .rdata (dp_rdata),
    .full  (dp_full),
    .empty (dp_empty)
  );

  // FSM, clear sweep counter and registered BRAM port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_src  <= SRC_DP;
      clr_cnt   <= '0;
      clr_val_q <= '0;
      vga_waddr <= '0;
      dina      <= '0;
      ena       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ena <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            clr_val_q <= clear_val;
            busy      <= 1'b1;
          end else if (rf_grant) begin
            ena       <= 1'b1;
            vga_waddr <= rf_head[ENTRY_W-1:DATA_W];
            dina      <= rf_head[DATA_W-1:0];
            last_src  <= SRC_RF;
          end else if (dp_grant) begin
            ena       <= 1'b1;
            vga_waddr <= dp_head[ENTRY_W-1:DATA_W];
            dina      <= dp_head[DATA_W-1:0];
            last_src  <= SRC_DP;
          end
        end
        default: begin
          ena       <= 1'b1;
          vga_waddr <= clr_cnt;
          dina      <= clr_val_q;
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Sticky overflow flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_ovf <= 1'b0;
      dp_ovf <= 1'b0;
    end else begin
      rf_ovf <= rf_ovf | rf_drop;
      dp_ovf <= dp_ovf | dp_drop;
    end
  end

  assign wea = ena;

endmodule

// File: tb/tb_vga_map_wr_arbiter.sv
// Directed bench for vga_map_wr_arbiter with a shortened map (40 words).
module tb_vga_map_wr_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int WORDS = 40;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] rf_addr, dp_addr, vga_waddr;
  logic [DW-1:0] rf_data, dp_data, clear_val, dina;
  logic          rf_wen, dp_wen, mode, clear_req;
  logic          ena, wea, busy, rf_ovf, dp_ovf;

  vga_map_wr_arbiter #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .MAP_WORDS(WORDS)
  ) dut (
    .clk(clk), .reset(reset),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_wen(rf_wen),
    .dp_addr(dp_addr), .dp_data(dp_data), .dp_wen(dp_wen),
    .mode(mode), .clear_req(clear_req), .clear_val(clear_val),
    .vga_waddr(vga_waddr), .dina(dina), .ena(ena), .wea(wea),
    .busy(busy), .rf_ovf(rf_ovf), .dp_ovf(dp_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cycles = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard capture of every port write, plus busy-cycle count.
  always @(negedge clk) begin
    if (!reset) begin
      if (ena === 1'b1) begin
        obs_q.push_back({vga_waddr, dina});
        check("wea_follows_ena", {31'd0, wea}, 32'd1);
      end
      if (busy === 1'b1) busy_cycles++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rf_wen = 1'b0; rf_addr = '0; rf_data = '0;
    dp_wen = 1'b0; dp_addr = '0; dp_data = '0;
    clear_req = 1'b0; clear_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mode  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    busy_cycles = 0;
  endtask

  task automatic drive_rf(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_inputs(); mode = 1'b0; rf_wen = 1'b1; rf_addr = a; rf_data = d;
    tick();
  endtask

  task automatic drive_dp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_inputs(); mode = 1'b1; dp_wen = 1'b1; dp_addr = a; dp_data = d;
    tick();
  endtask

  task automatic start_clear(input logic [DW-1:0] v);
    idle_inputs(); clear_req = 1'b1; clear_val = v;
    tick();
    clear_req = 1'b0;
  endtask

  task automatic push_clear_exp(input logic [DW-1:0] v);
    for (int i = 0; i < WORDS; i++) exp_q.push_back({AW'(i), v});
  endtask

  task automatic wait_sweep_end(input int drain);
    int k;
    idle_inputs();
    for (k = 0; k < 300; k++) begin
      if (busy === 1'b0) break;
      tick();
    end
    check("sweep_end_timeout", {31'd0, busy}, 32'd0);
    repeat (drain) tick();
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) check({name, "_entry"}, obs_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic          mode;
    logic          rf_wen;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          dp_wen;
    logic [AW-1:0] dp_addr;
    logic [DW-1:0] dp_data;
    logic          e_ena;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_rf_ovf;
    logic          e_dp_ovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 19'd0,  8'h00, 1'b0, 19'd0,  8'h00, 1'b0, 19'd0,  8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 19'd5,  8'hFF, 1'b1, 19'd7,  8'h11, 1'b1, 19'd5,  8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 19'd6,  8'h01, 1'b0, 19'd0,  8'h00, 1'b1, 19'd6,  8'h01, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 19'd3,  8'h33, 1'b1, 19'd9,  8'h22, 1'b1, 19'd9,  8'h22, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 19'd0,  8'h00, 1'b1, 19'd10, 8'h44, 1'b1, 19'd10, 8'h44, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 19'd39, 8'h55, 1'b0, 19'd0,  8'h00, 1'b1, 19'd39, 8'h55, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 19'd0,  8'h00, 1'b0, 19'd0,  8'h00, 1'b0, 19'd0,  8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 19'd40, 8'h66, 1'b0, 19'd0,  8'h00, 1'b0, 19'd0,  8'h00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 19'd0,  8'h00, 1'b1, 19'd50, 8'h77, 1'b0, 19'd0,  8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 19'd0,  8'h00, 1'b1, 19'd40, 8'h88, 1'b0, 19'd0,  8'h00, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 19'd0,  8'h00, 1'b1, 19'd0,  8'h99, 1'b1, 19'd0,  8'h99, 1'b1, 1'b1};

    do_reset();
    check("rst_ena", {31'd0, ena}, 32'd0);
    check("rst_wea", {31'd0, wea}, 32'd0);
    check("rst_waddr", {13'd0, vga_waddr}, 32'd0);
    check("rst_dina", {24'd0, dina}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rf_ovf", {31'd0, rf_ovf}, 32'd0);
    check("rst_dp_ovf", {31'd0, dp_ovf}, 32'd0);

    // Table: single-cycle acceptance, selection, range and flag behaviour.
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      mode    = tbl[i].mode;
      rf_wen  = tbl[i].rf_wen;  rf_addr = tbl[i].rf_addr; rf_data = tbl[i].rf_data;
      dp_wen  = tbl[i].dp_wen;  dp_addr = tbl[i].dp_addr; dp_data = tbl[i].dp_data;
      tick();
      check($sformatf("vec%0d_ena", i), {31'd0, ena}, {31'd0, tbl[i].e_ena});
      if (tbl[i].e_ena) begin
        check($sformatf("vec%0d_waddr", i), {13'd0, vga_waddr}, {13'd0, tbl[i].e_addr});
        check($sformatf("vec%0d_dina", i), {24'd0, dina}, {24'd0, tbl[i].e_data});
      end
      check($sformatf("vec%0d_rf_ovf", i), {31'd0, rf_ovf}, {31'd0, tbl[i].e_rf_ovf});
      check($sformatf("vec%0d_dp_ovf", i), {31'd0, dp_ovf}, {31'd0, tbl[i].e_dp_ovf});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Sweep with both sources queued: round-robin starts with rf after reset.
    do_reset();
    start_clear(8'hA5);
    check("a_busy_rise", {31'd0, busy}, 32'd1);
    check("a_no_write_on_start", {31'd0, ena}, 32'd0);
    push_clear_exp(8'hA5);
    for (int i = 0; i < 4; i++) drive_rf(AW'(20 + i), DW'(8'h10 + i));
    for (int i = 0; i < 4; i++) drive_dp(AW'(30 + i), DW'(8'h20 + i));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({AW'(20 + i), DW'(8'h10 + i)});
      exp_q.push_back({AW'(30 + i), DW'(8'h20 + i)});
    end
    wait_sweep_end(12);
    check("a_busy_cycles", busy_cycles, WORDS);
    compare_queues("a_writes");
    check("a_rf_ovf", {31'd0, rf_ovf}, 32'd0);
    check("a_dp_ovf", {31'd0, dp_ovf}, 32'd0);

    // Full-rate stream, then 17 rf writes into a 16-deep FIFO during a sweep.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_rf(AW'(i), DW'(8'hC0 + i));
      exp_q.push_back({AW'(i), DW'(8'hC0 + i)});
    end
    check("b_stream_no_ovf", {31'd0, rf_ovf}, 32'd0);
    idle_inputs();
    tick();
    start_clear(8'h5A);
    push_clear_exp(8'h5A);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("b_ovf_before_17th", {31'd0, rf_ovf}, 32'd0);
      drive_rf(AW'(i), DW'(8'h40 + i));
      if (i < 16) exp_q.push_back({AW'(i), DW'(8'h40 + i)});
    end
    check("b_ovf_after_17th", {31'd0, rf_ovf}, 32'd1);
    wait_sweep_end(25);
    check("b_busy_cycles", busy_cycles, WORDS);
    compare_queues("b_writes");
    check("b_rf_ovf_sticky", {31'd0, rf_ovf}, 32'd1);
    check("b_dp_ovf", {31'd0, dp_ovf}, 32'd0);

    // Reset mid-sweep, then a fresh sweep restarts at address 0.
    do_reset();
    start_clear(8'h3C);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (ena === 1'b1 && vga_waddr == AW'(10)) break;
        tick();
      end
      check("c_reach_addr10", {13'd0, vga_waddr}, 32'd10);
    end
    reset = 1'b1;
    tick();
    check("c_rst_ena", {31'd0, ena}, 32'd0);
    check("c_rst_wea", {31'd0, wea}, 32'd0);
    check("c_rst_waddr", {13'd0, vga_waddr}, 32'd0);
    check("c_rst_dina", {24'd0, dina}, 32'd0);
    check("c_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    start_clear(8'h77);
    tick();
    check("c_restart_ena", {31'd0, ena}, 32'd1);
    check("c_restart_addr", {13'd0, vga_waddr}, 32'd0);
    check("c_restart_data", {24'd0, dina}, 32'h77);
    tick();
    check("c_second_addr", {13'd0, vga_waddr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
